tcp_rx_read_engine: RTL

- Application-side receive engine for the TCP offload stack's app interface; it is the receive-path counterpart of the transmit path (tx_metadata, tx_data, tx_status).
- Accepts stack notifications and issues read_package requests. It then consumes rx_metadata and rx_data and forwards each payload to a user stream with a per-packet header.
- Maintains packet, byte and drop statistics readable by the host ILA/registers.

---
 rtl/tcp_rx_read_engine.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/tcp_rx_read_engine.sv
// TCP offload app-side receive engine: notification -> read request -> metadata -> header + payload.
// Optional latency statistics (lat_last/lat_max/lat_sum) are built when TCP_RX_LATENCY_EN is defined.
//
// state | meaning
// IDLE  | accept notifications, count and discard invalid ones
// REQ   | present read_package request for the latched session/length
// META  | consume rx_metadata, flag a session mismatch
// HDR   | present app header for the packet
// DATA  | stream payload through the skid buffer until the last beat has left
module tcp_rx_read_engine #(
    parameter int DATA_WIDTH  = 512,
    parameter int KEEP_WIDTH  = DATA_WIDTH/8,
    parameter int MAX_PKT_LEN = 1460
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_notif_valid,
    output logic                  s_notif_ready,
    input  logic [87:0]           s_notif_data,
    output logic                  m_read_pkg_valid,
    input  logic                  m_read_pkg_ready,
    output logic [31:0]           m_read_pkg_data,
    input  logic                  s_rx_meta_valid,
    output logic                  s_rx_meta_ready,
    input  logic [15:0]           s_rx_meta_data,
    input  logic                  s_rx_data_valid,
    output logic                  s_rx_data_ready,
    input  logic                  s_rx_data_last,
    input  logic [DATA_WIDTH-1:0] s_rx_data_data,
    input  logic [KEEP_WIDTH-1:0] s_rx_data_keep,
    output logic                  m_app_meta_valid,
    input  logic                  m_app_meta_ready,
    output logic [31:0]           m_app_meta_data,
    output logic                  m_app_data_valid,
    input  logic                  m_app_data_ready,
    output logic                  m_app_data_last,
    output logic [DATA_WIDTH-1:0] m_app_data_data,
    output logic [KEEP_WIDTH-1:0] m_app_data_keep,
    output logic [31:0]           pkt_cnt,
    output logic [63:0]           byte_cnt,
    output logic [31:0]           drop_cnt,
    output logic                  err_session
`ifdef TCP_RX_LATENCY_EN
    ,
    output logic [31:0]           lat_last,
    output logic [31:0]           lat_max,
    output logic [63:0]           lat_sum
`endif
);
    localparam int          BEAT_W  = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);

    typedef enum logic [2:0] {IDLE, REQ, META, HDR, DATA} state_t;

    state_t              state;
    logic [1:0]          rst_sync;
    logic                rst_n;
    logic [15:0]         cur_session;
    logic [15:0]         cur_len;
    logic [BEAT_W-1:0]   skid0;
    logic [BEAT_W-1:0]   skid1;
    logic [BEAT_W-1:0]   beat_in;
    logic [1:0]          skid_cnt;
    logic                last_in;
    logic                push;
    logic                pop;
    logic [15:0]         notif_session;
    logic [15:0]         notif_len;
    logic                notif_drop;
    logic                notif_hs;
    logic                unused_notif;

    // Reset asserts asynchronously, releases on the clock.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign notif_session = s_notif_data[15:0];
    assign notif_len     = s_notif_data[31:16];
    assign notif_drop    = s_notif_data[80] || (notif_len == 16'd0) || (notif_len > MAX_LEN);
    assign notif_hs      = s_notif_valid && s_notif_ready;
    assign unused_notif  = ^{s_notif_data[87:81], s_notif_data[79:32]};

    assign m_read_pkg_data = {cur_len, cur_session};
    assign m_app_meta_data = {cur_len, cur_session};

    // Once the last beat is in, no further beat may enter until the next header has gone out.
    assign s_rx_data_ready  = (state == DATA) && !last_in && (skid_cnt != 2'd2);
    assign push             = s_rx_data_valid && s_rx_data_ready;
    assign m_app_data_valid = (skid_cnt != 2'd0);
    assign pop              = m_app_data_valid && m_app_data_ready;
    assign beat_in          = {s_rx_data_last, s_rx_data_keep, s_rx_data_data};
    assign {m_app_data_last, m_app_data_keep, m_app_data_data} = skid0;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            s_notif_ready    <= 1'b0;
            m_read_pkg_valid <= 1'b0;
            s_rx_meta_ready  <= 1'b0;
            m_app_meta_valid <= 1'b0;
            cur_session      <= '0;
            cur_len          <= '0;
            last_in          <= 1'b0;
            pkt_cnt          <= '0;
            byte_cnt         <= '0;
            drop_cnt         <= '0;
            err_session      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    s_notif_ready <= 1'b1;
                    if (notif_hs) begin
                        cur_session <= notif_session;
                        cur_len     <= notif_len;
                        if (notif_drop) begin
                            drop_cnt <= drop_cnt + 32'd1;
                        end else begin
                            s_notif_ready    <= 1'b0;
                            m_read_pkg_valid <= 1'b1;
                            state            <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (m_read_pkg_ready) begin
                        m_read_pkg_valid <= 1'b0;
                        s_rx_meta_ready  <= 1'b1;
                        state            <= META;
                    end
                end
                META: begin
                    if (s_rx_meta_valid) begin
                        if (s_rx_meta_data != cur_session) err_session <= 1'b1;
                        s_rx_meta_ready  <= 1'b0;
                        m_app_meta_valid <= 1'b1;
                        state            <= HDR;
                    end
                end
                HDR: begin
                    if (m_app_meta_ready) begin
                        m_app_meta_valid <= 1'b0;
                        state            <= DATA;
                    end
                end
                DATA: begin
                    if (push && s_rx_data_last) begin
                        last_in  <= 1'b1;
                        pkt_cnt  <= pkt_cnt + 32'd1;
                        byte_cnt <= byte_cnt + {48'd0, cur_len};
                    end
                    if (pop && m_app_data_last) begin
                        last_in       <= 1'b0;
                        s_notif_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry skid: head in skid0 drives the output, skid1 absorbs one beat of back-pressure.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            skid0    <= '0;
            skid1    <= '0;
            skid_cnt <= 2'd0;
        end else if (push && !pop) begin
            if (skid_cnt == 2'd0) skid0 <= beat_in;
            else                  skid1 <= beat_in;
            skid_cnt <= skid_cnt + 2'd1;
        end else if (!push && pop) begin
            skid0    <= skid1;
            skid_cnt <= skid_cnt - 2'd1;
        end else if (push && pop) begin
            skid0 <= beat_in;
        end
    end

`ifdef TCP_RX_LATENCY_EN
    logic [31:0] lat_timer;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            lat_timer <= '0;
            lat_last  <= '0;
            lat_max   <= '0;
            lat_sum   <= '0;
        end else begin
            if (state == IDLE && notif_hs && !notif_drop) lat_timer <= 32'd1;
            else if (state != IDLE)                       lat_timer <= lat_timer + 32'd1;
            if (state == DATA && pop && m_app_data_last) begin
                lat_last <= lat_timer;
                if (lat_timer > lat_max) lat_max <= lat_timer;
                lat_sum <= lat_sum + {32'd0, lat_timer};
            end
        end
    end
`endif

endmodule
